fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Credit-gated instruction fetch queue with redirect flush/drain.
//            Optional same-cycle response bypass: FETCH_QUEUE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CW = c_AW + 1;
  localparam logic [c_CW:0] c_DEPTH_CNT = DEPTH[c_CW:0];

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_fetch_pc;
  logic [31:0]       r_rsp_pc;
  logic [c_CW-1:0]   r_count;
  logic [c_CW-1:0]   r_out;
  logic [c_CW-1:0]   r_drop;
  logic [c_CW-1:0]   w_drop_nxt;
  logic [c_CW-1:0]   w_out_nxt;
  logic [c_AW-1:0]   r_head;
  logic [c_AW-1:0]   r_tail;
  logic [31:0]       r_inst_mem [DEPTH];
  logic [31:0]       r_pc_mem   [DEPTH];

  logic              w_run;
  logic              w_q_empty;
  logic [c_CW:0]     w_credit_sum;
  logic              w_has_credit;
  logic              w_req_fire;
  logic              w_rsp_run;
  logic              w_push;
  logic              w_pop;

  assign w_run        = (r_state == RUN);
  assign w_q_empty    = (r_count == '0);
  assign w_credit_sum = {1'b0, r_count} + {1'b0, r_out};
  assign w_has_credit = (w_credit_sum < c_DEPTH_CNT);

  // Reset gates the request so nothing leaks out while state is held.
  assign imem_req_valid = !rst && w_run && !redirect_valid && w_has_credit;
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_rsp_run = imem_rsp_valid && w_run && !redirect_valid;
  assign w_pop     = !redirect_valid && !w_q_empty && id_ready;
  assign w_out_nxt = r_out + c_CW'(w_req_fire) - c_CW'(imem_rsp_valid);

`ifdef FETCH_QUEUE_BYPASS_EN
  logic w_bypass;

  // An empty queue forwards the arriving response; it is stored only if not taken.
  assign w_bypass = w_q_empty && w_run && imem_rsp_valid;
  assign id_valid = !rst && (!w_q_empty || w_bypass);
  assign id_inst  = w_q_empty ? imem_rsp_data : r_inst_mem[r_head];
  assign id_pc    = w_q_empty ? r_rsp_pc      : r_pc_mem[r_head];
  assign w_push   = w_rsp_run && !(w_bypass && id_ready);
`else
  assign id_valid = !w_q_empty;
  assign id_inst  = r_inst_mem[r_head];
  assign id_pc    = r_pc_mem[r_head];
  assign w_push   = w_rsp_run;
`endif

  // Drop count: a redirect in RUN inherits every in-flight response; a
  // redirect in DRAIN keeps what is still owed.
  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop;
    if (redirect_valid) begin
      w_drop_nxt  = ((r_state == RUN) ? r_out : r_drop) - c_CW'(imem_rsp_valid);
      w_state_nxt = (w_drop_nxt != '0) ? DRAIN : RUN;
    end else if ((r_state == DRAIN) && imem_rsp_valid) begin
      w_drop_nxt = r_drop - c_CW'(1);
      if (w_drop_nxt == '0) begin
        w_state_nxt = RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_drop  <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_drop_nxt;
      r_out   <= w_out_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
      r_rsp_pc   <= redirect_pc;
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + 32'd1;
      end
      if (w_rsp_run) begin
        r_rsp_pc <= r_rsp_pc + 32'd1;
      end
      if (w_push) begin
        r_tail <= r_tail + c_AW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + c_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_inst_mem[r_tail] <= imem_rsp_data;
      r_pc_mem[r_tail]   <= r_rsp_pc;
    end
  end

endmodule
`default_nettype wire
